ddr_wr_arbiter: RTL and testbench
=================================

Name: ddr_wr_arbiter

Overview:
- Responder side of the DDR Write Arbiter I/F (dwr_*) used by the pipeline stages (rect, gftt, ...).
- Grants one of two client ports round-robin and captures one fixed-length write burst (address beat plus data beats) into an internal buffer.
- Replays the captured burst on a simplified AXI3/4 write master port toward the PS DDR.
- Clients have no backpressure, so the whole burst is buffered before AXI issue.

Parameters:
- BURST_LEN, 16, data beats per burst (2..256); awlen = BURST_LEN-1.
- NCLI, 2, number of client ports (fixed at 2 in this revision).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- c0_dwr_req  in  1  client 0 request (level)
- c0_dwr_ack  out  1  client 0 grant (level)
- c0_dwr_vin  in  1  client 0 beat valid
- c0_dwr_din  in  32  client 0 beat data (beat 0 = byte address)
- c0_dwr_strb  in  4  client 0 byte strobes (ignored on address beat)
- c1_dwr_req, c1_dwr_ack, c1_dwr_vin, c1_dwr_din, c1_dwr_strb  same as c0
- m_awvalid  out  1,  m_awready  in  1,  m_awaddr  out  32,  m_awlen  out  8
- m_wvalid  out  1,  m_wready  in  1,  m_wdata  out  32,  m_wstrb  out  4,  m_wlast  out  1
- m_bvalid  in  1,  m_bready  out  1
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; rr pointer favours c0; beat counters 0.
- FSM states: IDLE, CAPT, AW, W, B.
- IDLE:
  - If any req is set, grant on the next edge and go to CAPT.
  - Both requests set: grant the client not served last (rr pointer); first grant after reset goes to c0.
  - Pointer updates when the grant is issued.
- CAPT:
  - cX_dwr_ack is held high for the whole state.
  - Beats are counted only when vin=1 on the granted port. Gaps are allowed.
  - Beat 0 goes to the address register, with addr[1:0] forced to 0.
  - Beats 1..BURST_LEN go to the buffer as {din, strb} at index beat-1.
  - The cycle the last beat is captured, go to AW; ack falls on the next edge, one cycle after the last beat.
  - vin on the non-granted port, or any vin outside CAPT, is ignored. req falling during CAPT does not abort the capture.
- AW: m_awvalid=1, m_awaddr=address, m_awlen=BURST_LEN-1. Hold until m_awready, then go to W.
- W:
  - m_wvalid=1, data and strobe presented from buffer index 0 upward.
  - Advance on m_wvalid&m_wready. m_wlast=1 on index BURST_LEN-1.
  - Data and strobe stay stable while m_wready=0.
  - After the last handshake, go to B.
- B:
  - m_bready=1. On m_bvalid, return to IDLE; the bresp value is not checked.
  - A new grant may be issued on the cycle after returning to IDLE.
- Latency, single client, no stalls, back-to-back vin:
  - ack rises 1 cycle after req.
  - awvalid rises 1 cycle after the last beat.
  - The first wvalid is on the cycle after the AW handshake.
- Buffer: BURST_LEN x 36 bits, single port. The write and read phases are mutually exclusive, so no full/empty flags are needed; the beat count is the index.
- Reset mid-operation: immediate return to reset values; any partially captured burst or in-flight AXI transaction is discarded. Asserting rst is only legal as a global reset.

Test Plan:
- Single c0 burst: req; beats addr=0x1000_0003 then data 0..15 with strb=F -> ack high 17 capture cycles; awaddr=0x1000_0000, awlen=15; 16 W beats 0..15; wlast on beat 15; busy low after bvalid.
- Both requests in the same cycle, held, BURST_LEN=16 -> order c0, c1, c0, c1 across 4 bursts; ack never overlaps between ports.
- vin gaps: c1 sends beats with vin toggling 1/0 -> exactly 17 beats counted; data order preserved; ack falls 1 cycle after the 17th beat.
- W backpressure: m_wready low on alternate cycles, strb pattern 1,2,4,8 repeating -> wdata/wstrb stable while stalled; 16 handshakes; wlast only on the 16th.
- AW and B stalls: awready delayed 5 cycles, bvalid delayed 10 -> awvalid held with address stable; no new ack issued until after bvalid.
- Reset mid-capture after 5 beats -> all outputs 0 asynchronously; the next c0 burst completes correctly with the address taken from its own beat 0.

Source files
------------

// File: rtl/ddr_wr_arbiter.sv
// Round-robin DDR write arbiter: captures one fixed-length burst from one of two
// clients into a local buffer, then replays it as a single AXI write transaction.
`timescale 1ns/1ps
module ddr_wr_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int NCLI      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_dwr_req,
  output logic        c0_dwr_ack,
  input  logic        c0_dwr_vin,
  input  logic [31:0] c0_dwr_din,
  input  logic [3:0]  c0_dwr_strb,
  input  logic        c1_dwr_req,
  output logic        c1_dwr_ack,
  input  logic        c1_dwr_vin,
  input  logic [31:0] c1_dwr_din,
  input  logic [3:0]  c1_dwr_strb,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CAPT, S_AW, S_W, S_B} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt_q, gnt_d;
  logic            pri_q, pri_d;
  logic [31:0]     addr_q;
  logic [35:0]     buf_mem [BURST_LEN];
  logic [NCLI-1:0] ack_vec;

  logic        vin_sel;
  logic [31:0] din_sel;
  logic [3:0]  strb_sel;
  logic        cap_beat;
  logic        cap_last;
  logic        w_last;
  logic [35:0] rd_word;

  assign vin_sel  = gnt_q ? c1_dwr_vin  : c0_dwr_vin;
  assign din_sel  = gnt_q ? c1_dwr_din  : c0_dwr_din;
  assign strb_sel = gnt_q ? c1_dwr_strb : c0_dwr_strb;
  assign cap_beat = (state_q == S_CAPT) && vin_sel;
  assign cap_last = (cnt_q == CW'(BURST_LEN));
  assign w_last   = (cnt_q == CW'(BURST_LEN - 1));
  assign rd_word  = buf_mem[IW'(cnt_q)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      pri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      pri_q   <= pri_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    pri_d   = pri_q;
    case (state_q)
      S_IDLE: begin
        if (c0_dwr_req || c1_dwr_req) begin
          // pri_q names the client that wins a tie; it flips away from each winner
          gnt_d   = (c0_dwr_req && c1_dwr_req) ? pri_q : c1_dwr_req;
          pri_d   = ~gnt_d;
          cnt_d   = '0;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (cap_beat) begin
          if (cap_last) begin
            cnt_d   = '0;
            state_d = S_AW;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_AW: begin
        if (m_awready) state_d = S_W;
      end
      S_W: begin
        if (m_wready) begin
          if (w_last) begin
            cnt_d   = '0;
            state_d = S_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_B: begin
        if (m_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat 0 is the byte address; data beats land at index beat-1.
  always_ff @(posedge clk) begin
    if (cap_beat) begin
      if (cnt_q == '0) addr_q <= {din_sel[31:2], 2'b00};
      else             buf_mem[IW'(cnt_q - CW'(1))] <= {din_sel, strb_sel};
    end
  end

  always_comb begin
    ack_vec = '0;
    if (state_q == S_CAPT) ack_vec[gnt_q] = 1'b1;
  end

  assign c0_dwr_ack = ack_vec[0];
  assign c1_dwr_ack = ack_vec[1];

  // Data-side outputs are gated so every output reads 0 outside its phase.
  assign m_awvalid = (state_q == S_AW);
  assign m_awaddr  = m_awvalid ? addr_q : '0;
  assign m_awlen   = m_awvalid ? 8'(BURST_LEN - 1) : '0;
  assign m_wvalid  = (state_q == S_W);
  assign m_wdata   = m_wvalid ? rd_word[35:4] : '0;
  assign m_wstrb   = m_wvalid ? rd_word[3:0] : '0;
  assign m_wlast   = m_wvalid && w_last;
  assign m_bready  = (state_q == S_B);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Scoreboard bench for ddr_wr_arbiter: client tasks push expected AXI traffic,
// a monitor pops and compares on every AW/W handshake and every grant.
`timescale 1ns/1ps
module tb_ddr_wr_arbiter;
  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_dwr_req, c0_dwr_ack, c0_dwr_vin;
  logic [31:0] c0_dwr_din;
  logic [3:0]  c0_dwr_strb;
  logic        c1_dwr_req, c1_dwr_ack, c1_dwr_vin;
  logic [31:0] c1_dwr_din;
  logic [3:0]  c1_dwr_strb;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic        busy;

  ddr_wr_arbiter #(.BURST_LEN(BL), .NCLI(2)) dut (
    .clk(clk), .rst(rst),
    .c0_dwr_req(c0_dwr_req), .c0_dwr_ack(c0_dwr_ack), .c0_dwr_vin(c0_dwr_vin),
    .c0_dwr_din(c0_dwr_din), .c0_dwr_strb(c0_dwr_strb),
    .c1_dwr_req(c1_dwr_req), .c1_dwr_ack(c1_dwr_ack), .c1_dwr_vin(c1_dwr_vin),
    .c1_dwr_din(c1_dwr_din), .c1_dwr_strb(c1_dwr_strb),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_aw_q[$];
  logic [36:0] exp_w_q[$];
  int          exp_gnt_q[$];

  int aw_delay = 0;
  int b_delay  = 0;
  bit w_alt    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input int cli);
    return (cli == 0) ? c0_dwr_ack : c1_dwr_ack;
  endfunction

  task automatic set_req(input int cli, input logic v);
    if (cli == 0) c0_dwr_req = v;
    else          c1_dwr_req = v;
  endtask

  task automatic drv(input int cli, input logic v, input logic [31:0] d, input logic [3:0] s);
    if (cli == 0) begin
      c0_dwr_vin = v; c0_dwr_din = d; c0_dwr_strb = s;
    end else begin
      c1_dwr_vin = v; c1_dwr_din = d; c1_dwr_strb = s;
    end
  endtask

  // AXI responder with programmable AW/B delays and optional alternate-cycle wready
  initial begin
    int aw_cnt;
    int b_cnt;
    bit w_tog;
    aw_cnt = 0; b_cnt = 0; w_tog = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        aw_cnt = 0; b_cnt = 0;
      end else begin
        m_awready = m_awvalid && (aw_cnt >= aw_delay);
        aw_cnt    = m_awvalid ? aw_cnt + 1 : 0;
        w_tog     = ~w_tog;
        m_wready  = w_alt ? w_tog : 1'b1;
        m_bvalid  = m_bready && (b_cnt >= b_delay);
        b_cnt     = m_bready ? b_cnt + 1 : 0;
      end
    end
  end

  // Monitor: handshakes, stall stability, grant order, ack exclusivity
  initial begin
    bit          aw_stall, w_stall, pa0, pa1;
    logic [31:0] prev_awaddr;
    logic [36:0] prev_w;
    aw_stall = 0; w_stall = 0; pa0 = 0; pa1 = 0;
    prev_awaddr = '0; prev_w = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        aw_stall = 0; w_stall = 0; pa0 = 0; pa1 = 0;
      end else begin
        if (aw_stall) chk("aw_stable", {m_awvalid, m_awaddr}, {1'b1, prev_awaddr});
        if (w_stall)  chk("w_stable", {m_wvalid, m_wdata, m_wstrb, m_wlast}, {1'b1, prev_w});
        if (m_awvalid && m_awready) begin
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            chk("awaddr", m_awaddr, exp_aw_q.pop_front());
            chk("awlen", m_awlen, BL - 1);
          end
        end
        if (m_wvalid && m_wready) begin
          if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
          else chk("wbeat", {m_wdata, m_wstrb, m_wlast}, exp_w_q.pop_front());
        end
        aw_stall    = m_awvalid && !m_awready;
        prev_awaddr = m_awaddr;
        w_stall     = m_wvalid && !m_wready;
        prev_w      = {m_wdata, m_wstrb, m_wlast};
        if (c0_dwr_ack || c1_dwr_ack) chk("ack_overlap", c0_dwr_ack & c1_dwr_ack, 0);
        if (c0_dwr_ack && !pa0) begin
          if (exp_gnt_q.size() == 0) chk("grant_unexpected", 0, 9);
          else chk("grant_order", 0, exp_gnt_q.pop_front());
        end
        if (c1_dwr_ack && !pa1) begin
          if (exp_gnt_q.size() == 0) chk("grant_unexpected", 1, 9);
          else chk("grant_order", 1, exp_gnt_q.pop_front());
        end
        pa0 = c0_dwr_ack;
        pa1 = c1_dwr_ack;
      end
    end
  end

  task automatic send_burst(input int cli, input logic [31:0] addr, input logic [31:0] dbase,
                            input bit strb_walk, input bit gaps, input bit chk_lat);
    int n;
    logic [3:0] s;
    set_req(cli, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!get_ack(cli) && n < 400);
    if (!get_ack(cli)) begin
      checks++; failures++;
      $display("FAIL ack_timeout cli=%0d actual=0 required=1", cli);
      return;
    end
    if (chk_lat) chk("ack_latency", n, 1);
    for (int b = 0; b <= BL; b++) begin
      if (gaps && (b % 2 == 1)) begin
        drv(cli, 1'b0, 32'hFFFF_FFFF, 4'h0);
        @(negedge clk);
      end
      if (b == 0)         s = 4'hA;
      else if (strb_walk) s = 4'h1 << ((b - 1) % 4);
      else                s = 4'hF;
      drv(cli, 1'b1, (b == 0) ? addr : dbase + b - 1, s);
      if (b == BL) chk("ack_last_beat", get_ack(cli), 1);
      @(negedge clk);
    end
    drv(cli, 1'b0, 32'h0, 4'h0);
    chk("ack_fall", get_ack(cli), 0);
    chk("awvalid_rise", m_awvalid, 1);
    exp_aw_q.push_back({addr[31:2], 2'b00});
    for (int i = 0; i < BL; i++) begin
      s = strb_walk ? (4'h1 << (i % 4)) : 4'hF;
      exp_w_q.push_back({dbase + i, s, (i == BL - 1)});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_aw_q.size() != 0 || exp_w_q.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("busy_idle", busy, 0);
    chk("sb_drained", exp_aw_q.size() + exp_w_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    bit seen_b;
    rst = 1'b1;
    c0_dwr_req = 0; c1_dwr_req = 0;
    drv(0, 0, 32'h0, 4'h0);
    drv(1, 0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("reset_outs", {c0_dwr_ack, c1_dwr_ack, m_awvalid, m_awaddr, m_awlen, m_wvalid,
                       m_wdata, m_wstrb, m_wlast, m_bready, busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    // single c0 burst
    exp_gnt_q.push_back(0);
    send_burst(0, 32'h1000_0003, 32'h0, 1'b0, 1'b0, 1'b1);
    set_req(0, 1'b0);
    wait_idle();

    // both clients held: c0, c1, c0, c1
    do_reset();
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    fork
      begin
        send_burst(0, 32'h2000_0000, 32'hA000_0000, 1'b0, 1'b0, 1'b0);
        send_burst(0, 32'h2000_0100, 32'hA100_0000, 1'b0, 1'b0, 1'b0);
        set_req(0, 1'b0);
      end
      begin
        send_burst(1, 32'h4000_0000, 32'hB000_0000, 1'b0, 1'b0, 1'b0);
        send_burst(1, 32'h4000_0100, 32'hB100_0000, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b0);
      end
    join
    wait_idle();
    chk("grants_consumed", exp_gnt_q.size(), 0);

    // c1 with vin gaps
    exp_gnt_q.push_back(1);
    send_burst(1, 32'h5000_0001, 32'hC000_0010, 1'b0, 1'b1, 1'b1);
    set_req(1, 1'b0);
    wait_idle();

    // W backpressure with walking strobes
    w_alt = 1'b1;
    exp_gnt_q.push_back(0);
    send_burst(0, 32'h6000_0040, 32'hD000_0000, 1'b1, 1'b0, 1'b1);
    set_req(0, 1'b0);
    wait_idle();
    w_alt = 1'b0;

    // AW and B stalls; c1 must not be granted before the write response
    aw_delay = 5; b_delay = 10;
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    send_burst(0, 32'h7000_0080, 32'hE000_0000, 1'b0, 1'b0, 1'b1);
    set_req(0, 1'b0);
    set_req(1, 1'b1);
    early = 0; seen_b = 0;
    for (int i = 0; i < 200 && !seen_b; i++) begin
      @(negedge clk);
      #1;
      if (c1_dwr_ack) early = 1;
      if (m_bvalid && m_bready) seen_b = 1;
    end
    chk("b_seen", seen_b, 1);
    chk("no_ack_before_b", early, 0);
    send_burst(1, 32'h7100_0000, 32'hE100_0000, 1'b0, 1'b0, 1'b0);
    set_req(1, 1'b0);
    wait_idle();
    aw_delay = 0; b_delay = 0;

    // reset in the middle of a capture, then a clean burst
    exp_gnt_q.push_back(0);
    set_req(0, 1'b1);
    @(negedge clk);
    chk("abort_ack", c0_dwr_ack, 1);
    for (int b = 0; b < 5; b++) begin
      drv(0, 1'b1, (b == 0) ? 32'hDEAD_0000 : 32'h5555_0000 + b, 4'hF);
      @(negedge clk);
    end
    drv(0, 1'b0, 32'h0, 4'h0);
    set_req(0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outs", {c0_dwr_ack, c1_dwr_ack, m_awvalid, m_wvalid, m_bready, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_gnt_q.push_back(0);
    send_burst(0, 32'h3000_0006, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    set_req(0, 1'b0);
    wait_idle();
    chk("grants_final", exp_gnt_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
